fc_dot_accum: RTL and testbench

//  Parametrised fixed-point dot-product accumulator for FC/1x1-conv layers; generalised successor of the 8-lane layer MAC.

---
 rtl/fc_dot_pkg.sv | 58 +++++
 rtl/fc_adder_tree.sv | 32 +++
 rtl/fc_dot_accum.sv | 135 +++++++++++++
 tb/tb_fc_dot_accum.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fc_dot_pkg.sv
// Shared types and arithmetic helpers for the fc_dot_accum datapath.
// Arithmetic helpers work on a wide signed container (calc_t) and clamp or
// wrap to a caller-supplied width, so one definition serves any DW <= 32.
// Build option: FC_DOT_SAT_EN selects saturating product slices and adds;
// when undefined every DW-bit add wraps modulo 2^DW.
package fc_dot_pkg;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_e;

  // Default Q-format: Q6.10 in 16 bits.
  localparam int DEF_DW   = 16;
  localparam int DEF_FRAC = 10;

  localparam int CALC_W = 64;
  typedef logic signed [CALC_W-1:0] calc_t;

  // Clamp v into the signed range of a w-bit number.
  function automatic calc_t sat_clamp(input calc_t v, input int w);
    calc_t hi;
    calc_t lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  function automatic calc_t sat_add(input calc_t a, input calc_t b, input int w);
    return sat_clamp(a + b, w);
  endfunction

  // Arithmetic shift floors; clamping the shifted value is equivalent to
  // checking that the discarded high bits are a pure sign extension.
  function automatic calc_t sat_slice(input calc_t prod, input int w, input int frac);
    return sat_clamp(prod >>> frac, w);
  endfunction

  // Datapath add: saturating or wrapping depending on build. In the wrapping
  // build the caller keeps only the low w bits.
  function automatic calc_t dw_add(input calc_t a, input calc_t b, input int w);
`ifdef FC_DOT_SAT_EN
    return sat_add(a, b, w);
`else
    if (w < 1) return a;
    return a + b;
`endif
  endfunction

  function automatic calc_t dw_slice(input calc_t prod, input int w, input int frac);
`ifdef FC_DOT_SAT_EN
    return sat_slice(prod, w, frac);
`else
    if (w < 1) return prod;
    return prod >>> frac;
`endif
  endfunction

endpackage

// File: rtl/fc_adder_tree.sv
// Balanced combinational adder tree: LANES signed DW-bit inputs -> one DW-bit
// sum. Each node uses dw_add, so it saturates under FC_DOT_SAT_EN and wraps
// otherwise.
// Ports:
//   in_vec  LANES x DW  operands
//   sum     DW          tree result
module fc_adder_tree
  import fc_dot_pkg::*;
#(
  parameter int LANES = 8,
  parameter int DW    = 16
) (
  input  logic [LANES-1:0][DW-1:0] in_vec,
  output logic [DW-1:0]            sum
);

  // Heap layout: node 1 is the root, node k has children 2k and 2k+1,
  // leaves occupy LANES .. 2*LANES-1.
  logic [DW-1:0] node [1:2*LANES-1];

  for (genvar i = 0; i < LANES; i++) begin : g_leaf
    assign node[LANES+i] = in_vec[i];
  end

  for (genvar k = 1; k < LANES; k++) begin : g_node
    assign node[k] = DW'(dw_add(calc_t'(signed'(node[2*k])),
                                calc_t'(signed'(node[2*k+1])), DW));
  end

  assign sum = node[1];

endmodule

// File: rtl/fc_dot_accum.sv
// Fixed-point dot-product accumulator for FC / 1x1-conv layers.
// Accepts LANES activation/weight pairs per beat, accumulates across a vector
// terminated by in_last (or forced at beat MAX_BEATS-1), adds a bias and
// presents one DW-bit result under valid/ready.
// Build option: FC_DOT_SAT_EN enables saturating arithmetic (see fc_dot_pkg).
// Ports:
//   clk, rst              clock, async active-high reset
//   in_valid/in_ready     beat handshake
//   in_data, in_weight    LANES*DW packed operands, lane i = [i*DW +: DW]
//   in_last               final beat of vector
//   bias                  captured with the last beat
//   out_valid/out_ready   result handshake
//   out_data              bias + accumulated sum
//   beat_cnt              beats accepted in current vector
module fc_dot_accum
  import fc_dot_pkg::*;
#(
  parameter int LANES     = 8,
  parameter int DW        = DEF_DW,
  parameter int FRAC      = DEF_FRAC,
  parameter int MAX_BEATS = 64,
  localparam int CW       = $clog2(MAX_BEATS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_data,
  input  logic [LANES*DW-1:0] in_weight,
  input  logic                in_last,
  input  logic [DW-1:0]       bias,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic [CW-1:0]       beat_cnt
);

  state_e                   state_q, state_d;
  logic [LANES-1:0][DW-1:0] prod_q, prod_d, prod_new;
  logic                     prod_vld_q, prod_vld_d;
  logic [DW-1:0]            acc_q, acc_d;
  logic [DW-1:0]            bias_q, bias_d;
  logic [DW-1:0]            out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic [CW-1:0]            beat_cnt_q, beat_cnt_d;

  logic          accept, is_last, out_hs;
  logic [DW-1:0] tree_sum, acc_cur;

  function automatic calc_t sx(input logic [DW-1:0] v);
    return calc_t'(signed'(v));
  endfunction

  // Stage-1 products: full 2*DW signed product, then Q-format slice.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [2*DW-1:0] p;
    assign p = signed'(in_data[i*DW +: DW]) * signed'(in_weight[i*DW +: DW]);
    assign prod_new[i] = DW'(dw_slice(calc_t'(p), DW, FRAC));
  end

  fc_adder_tree #(.LANES(LANES), .DW(DW)) u_tree (
    .in_vec (prod_q),
    .sum    (tree_sum)
  );

  assign in_ready = (state_q == IDLE) || (state_q == ACC);
  assign accept   = in_valid && in_ready;
  assign is_last  = in_last || (beat_cnt_q == CW'(MAX_BEATS - 1));
  assign out_hs   = out_valid_q && out_ready;

  // Accumulator value including the products registered last cycle; in DRAIN
  // this already holds the final beat, so the result is ready one cycle later.
  assign acc_cur = prod_vld_q ? DW'(dw_add(sx(acc_q), sx(tree_sum), DW)) : acc_q;

  always_comb begin
    state_d     = state_q;
    prod_d      = prod_q;
    prod_vld_d  = accept;
    acc_d       = acc_cur;
    bias_d      = bias_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    beat_cnt_d  = beat_cnt_q;

    if (accept) begin
      prod_d     = prod_new;
      beat_cnt_d = beat_cnt_q + CW'(1);
      if (is_last) bias_d = bias;
    end

    case (state_q)
      IDLE:  if (accept) state_d = is_last ? DRAIN : ACC;
      ACC:   if (accept && is_last) state_d = DRAIN;
      DRAIN: begin
        state_d     = OUT;
        out_valid_d = 1'b1;
        out_data_d  = DW'(dw_add(sx(acc_cur), sx(bias_q), DW));
      end
      OUT: if (out_hs) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        acc_d       = '0;
        beat_cnt_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      acc_q       <= '0;
      bias_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      prod_q      <= prod_d;
      prod_vld_q  <= prod_vld_d;
      acc_q       <= acc_d;
      bias_q      <= bias_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_fc_dot_accum.sv
// Scoreboard bench for fc_dot_accum (LANES=8, DW=16, FRAC=10, MAX_BEATS=4).
// Directed vectors push their hand-computed result into a queue; a monitor
// pops and compares on every output handshake.
module tb_fc_dot_accum;
  localparam int LANES = 8;
  localparam int DW    = 16;
  localparam int MAXB  = 4;
  localparam int CW    = $clog2(MAXB);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [LANES*DW-1:0] in_data = '0;
  logic [LANES*DW-1:0] in_weight = '0;
  logic                in_last = 1'b0;
  logic [DW-1:0]       bias = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [DW-1:0]       out_data;
  logic [CW-1:0]       beat_cnt;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] sb_q [$];

  fc_dot_accum #(.LANES(LANES), .DW(DW), .FRAC(10), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_weight(in_weight), .in_last(in_last), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every output handshake against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) check("unexpected_out", 32'(out_data), 32'hDEAD_BEEF);
      else check("out_data", 32'(out_data), 32'(sb_q.pop_front()));
    end
  end

  // Drive one beat (all lanes identical); returns at posedge+1 after acceptance.
  task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] w,
                           input logic last, input logic [DW-1:0] b);
    int n;
    n = 0;
    in_valid  = 1'b1;
    in_data   = {LANES{a}};
    in_weight = {LANES{w}};
    in_last   = last;
    bias      = b;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) check("beat_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_beat_cnt",  32'(beat_cnt),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // 1 beat 1.0*1.0 x8 + 0.5 bias -> 8.5, latency T+2
    sb_q.push_back(16'h2200);
    send_beat(16'h0400, 16'h0400, 1'b1, 16'h0200);
    check("lat_t1_out_valid", 32'(out_valid), 32'd0);
    check("lat_t1_in_ready",  32'(in_ready),  32'd0);
    @(posedge clk); #1;
    check("lat_t2_out_valid", 32'(out_valid), 32'd1);
    wait_drain();

    // 4 beats of 8.0 -> 32.0 overflows Q6.10
`ifdef FC_DOT_SAT_EN
    sb_q.push_back(16'h7FFF);
`else
    sb_q.push_back(16'h8000);
`endif
    for (int i = 0; i < 4; i++) send_beat(16'h0400, 16'h0400, i == 3, 16'h0000);
    wait_drain();

    // Mixed sign with output stall: -1.0*2.0 x8 + 1.0 -> -15.0
    out_ready = 1'b0;
    sb_q.push_back(16'hC400);
    send_beat(16'hFC00, 16'h0800, 1'b1, 16'h0400);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = {LANES{16'h0400}};
      in_weight = {LANES{16'h0400}};
      in_last = 1'b1;
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_data",  32'(out_data),  32'h0000_C400);
      check("stall_in_ready",  32'(in_ready),  32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    check("post_hs_beat_cnt",  32'(beat_cnt),  32'd0);
    check("post_hs_out_valid", 32'(out_valid), 32'd0);

    // Forced last at MAX_BEATS-1: 1.0*0.125 x8 = 1.0 per beat
    sb_q.push_back(16'h1000);
    sb_q.push_back(16'h0800);
    for (int i = 0; i < 6; i++) send_beat(16'h0400, 16'h0080, i == 5, 16'h0000);
    wait_drain();

    // Reset mid-vector
    for (int i = 0; i < 3; i++) send_beat(16'h0400, 16'h0400, 1'b0, 16'h0000);
    check("pre_rst_beat_cnt", 32'(beat_cnt), 32'd3);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_beat_cnt",  32'(beat_cnt),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    sb_q.push_back(16'h2000);
    send_beat(16'h0400, 16'h0400, 1'b1, 16'h0000);
    wait_drain();

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
